// File: rtl/bridge_fifo_pkg.sv
// bridge_fifo_pkg: status FSM encoding and default address width for the bridge FIFO controller.
package bridge_fifo_pkg;
  localparam int ASIZE_DEF = 5;
  typedef enum logic [1:0] {EMPTY = 2'b00, ACTIVE = 2'b01, FULL = 2'b10} state_e;
endpackage

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: wrap counter with increment, synchronous clear and sync active-low reset.
module fifo_ptr_cnt #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q;
  always_ff @(posedge clk_i)
    ptr_q <= (!rst_ni || clr_i) ? '0 : ptr_q + W'(inc_i);
  assign ptr_o = ptr_q;
endmodule

// File: rtl/bridge_fifo_ctrl.sv
// bridge_fifo_ctrl: pointer, occupancy and status control for an external dual-port FIFO memory.
module bridge_fifo_ctrl
  import bridge_fifo_pkg::*;
#(
  parameter int ASIZE    = ASIZE_DEF,
  parameter int AF_LEVEL = 2**ASIZE-2
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic             wclk_en,
  output logic             rclk_en,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE-1:0] raddr,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [ASIZE:0] DEPTH = (ASIZE+1)'(2**ASIZE);
  localparam logic [ASIZE:0] AF    = (ASIZE+1)'(AF_LEVEL);
  state_e         state_q, state_d;
  logic [ASIZE:0] wptr, rptr, count_q, count_d;
  logic           af_q, overflow_q, underflow_q;
  assign wclk_en = hresetn && push && !wfull && !flush;
  assign rclk_en = hresetn && pop && !rempty && !flush;
  assign count_d = count_q + (ASIZE+1)'(wclk_en) - (ASIZE+1)'(rclk_en);
  // Occupancy alone decides the next status: it can only cross 0 or DEPTH by one step.
  assign state_d = (count_d == '0) ? EMPTY : (count_d == DEPTH) ? FULL : ACTIVE;
  always_ff @(posedge hclk) begin
    if (!hresetn || flush) begin
      state_q     <= EMPTY;
      count_q     <= '0;
      af_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      af_q        <= count_d >= AF;
      overflow_q  <= overflow_q | (push & wfull);
      underflow_q <= underflow_q | (pop & rempty);
    end
  end
  fifo_ptr_cnt #(.W(ASIZE+1)) u_wptr (.clk_i(hclk), .rst_ni(hresetn), .clr_i(flush), .inc_i(wclk_en), .ptr_o(wptr));
  fifo_ptr_cnt #(.W(ASIZE+1)) u_rptr (.clk_i(hclk), .rst_ni(hresetn), .clr_i(flush), .inc_i(rclk_en), .ptr_o(rptr));
  assign waddr       = wptr[ASIZE-1:0];
  assign raddr       = rptr[ASIZE-1:0];
  assign wfull       = state_q == FULL;
  assign rempty      = state_q == EMPTY;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  a_ptr_count: assert property (@(posedge hclk) disable iff (!hresetn) (wptr - rptr) == count_q);
endmodule

// File: tb/tb_bridge_fifo_ctrl.sv
// tb_bridge_fifo_ctrl: scoreboard bench comparing bridge_fifo_ctrl (ASIZE=2) against an occupancy model.
module tb_bridge_fifo_ctrl;
  localparam int ASIZE = 2;
  localparam int D     = 2**ASIZE;
  localparam int AFL   = D-2;
  logic hclk, hresetn, push, pop, flush;
  logic wclk_en, rclk_en, wfull, rempty, almost_full, overflow, underflow;
  logic [ASIZE-1:0] waddr, raddr;
  logic [ASIZE:0] count;
  typedef struct {
    logic wen, ren, full, empty, af, ov, un;
    int   waddr, raddr, cnt;
  } exp_t;
  exp_t exp_q[$];
  int vectors = 0, miscompares = 0;
  int m_cnt = 0, m_w = 0, m_r = 0;
  logic m_ov = 0, m_un = 0;
  bridge_fifo_ctrl #(.ASIZE(ASIZE), .AF_LEVEL(AFL)) dut (
    .hclk(hclk), .hresetn(hresetn), .push(push), .pop(pop), .flush(flush),
    .wclk_en(wclk_en), .rclk_en(rclk_en), .waddr(waddr), .raddr(raddr),
    .wfull(wfull), .rempty(rempty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  initial hclk = 0;
  always #5 hclk = ~hclk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", n, $time, act, req);
    end
  endtask
  // One cycle of stimulus: record what the DUT must show this cycle, then advance the model past the edge.
  task automatic cyc(input logic rn, input logic pu, input logic po, input logic fl);
    exp_t e;
    @(posedge hclk); #1;
    hresetn = rn; push = pu; pop = po; flush = fl;
    e.wen = rn && pu && m_cnt < D && !fl;
    e.ren = rn && po && m_cnt > 0 && !fl;
    e.waddr = m_w % D; e.raddr = m_r % D; e.cnt = m_cnt;
    e.full = m_cnt == D; e.empty = m_cnt == 0; e.af = m_cnt >= AFL;
    e.ov = m_ov; e.un = m_un;
    exp_q.push_back(e);
    if (!rn || fl) begin
      m_cnt = 0; m_w = 0; m_r = 0; m_ov = 0; m_un = 0;
    end else begin
      if (pu && m_cnt == D) m_ov = 1;
      if (po && m_cnt == 0) m_un = 1;
      if (e.wen) begin m_w = (m_w + 1) % (2*D); m_cnt++; end
      if (e.ren) begin m_r = (m_r + 1) % (2*D); m_cnt--; end
    end
  endtask
  always @(negedge hclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk("wclk_en", 32'(wclk_en), 32'(e.wen));
      chk("rclk_en", 32'(rclk_en), 32'(e.ren));
      chk("waddr", 32'(waddr), e.waddr);
      chk("raddr", 32'(raddr), e.raddr);
      chk("count", 32'(count), e.cnt);
      chk("wfull", 32'(wfull), 32'(e.full));
      chk("rempty", 32'(rempty), 32'(e.empty));
      chk("almost_full", 32'(almost_full), 32'(e.af));
      chk("overflow", 32'(overflow), 32'(e.ov));
      chk("underflow", 32'(underflow), 32'(e.un));
    end
  end
  initial begin
    hresetn = 0; push = 1; pop = 1; flush = 0;
    repeat (2) @(posedge hclk);
    #1 push = 0; pop = 0;
    // fill, overflow attempt, push+pop while full, drain
    repeat (4) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 1, 0);
    repeat (5) cyc(1, 0, 1, 0);
    // wrap
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 1, 0, 0);
    repeat (4) cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
    // simultaneous push+pop at count 2
    cyc(0, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    // empty boundary
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(1, 0, 0, 0);
    // flush then reset with a pending push at count 3
    cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1); cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0); cyc(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit fill;
      fill = ((i / 40) % 2) == 0;
      cyc($urandom_range(299) != 0,
          $urandom_range(99) < (fill ? 75 : 30),
          $urandom_range(99) < (fill ? 30 : 75),
          $urandom_range(199) == 0);
    end
    cyc(1, 0, 0, 0);
    repeat (2) @(negedge hclk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
